// File: rtl/pie_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : pie_frame_tx
// Purpose  : Gen2-style PIE downlink envelope generator (delimiter, data-0,
//            RTcal, optional TRcal, PIE data) fed by a valid/ready bit stream.
// Revision : 1.0
// ============================================================================
module pie_frame_tx #(
  parameter int TARI_CYC  = 8,
  parameter int DATA1_CYC = 14,
  parameter int PW_CYC    = 4,
  parameter int DELIM_CYC = 10,
  parameter int TRCAL_CYC = 40,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic use_preamble,
  input  logic in_dat,
  input  logic in_last,
  input  logic in_vld,
  output logic in_rdy,
  output logic tx_env,
  output logic busy,
  output logic done,
  output logic underrun
);

  localparam logic [CNT_WIDTH-1:0] c_len_delim = CNT_WIDTH'(DELIM_CYC);
  localparam logic [CNT_WIDTH-1:0] c_len_tari  = CNT_WIDTH'(TARI_CYC);
  localparam logic [CNT_WIDTH-1:0] c_len_data1 = CNT_WIDTH'(DATA1_CYC);
  localparam logic [CNT_WIDTH-1:0] c_len_rtcal = CNT_WIDTH'(TARI_CYC + DATA1_CYC);
  localparam logic [CNT_WIDTH-1:0] c_len_trcal = CNT_WIDTH'(TRCAL_CYC);
  localparam logic [CNT_WIDTH-1:0] c_pw        = CNT_WIDTH'(PW_CYC);
  localparam logic [CNT_WIDTH-1:0] c_one       = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELIM = 3'd1,
    S_DATA0 = 3'd2,
    S_RTCAL = 3'd3,
    S_TRCAL = 3'd4,
    S_BITS  = 3'd5
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_pre;
  logic                 r_bit;
  logic                 r_last_bit;
  logic                 r_env;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_underrun;

  logic [CNT_WIDTH-1:0] w_len;
  logic [CNT_WIDTH-1:0] w_high;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic                 w_sym_end;
  logic                 w_fetch;

  always_comb begin
    w_len = c_len_tari;
    case (r_state)
      S_DELIM: w_len = c_len_delim;
      S_RTCAL: w_len = c_len_rtcal;
      S_TRCAL: w_len = c_len_trcal;
      S_BITS:  w_len = r_bit ? c_len_data1 : c_len_tari;
      default: w_len = c_len_tari;
    endcase
  end

  assign w_high    = w_len - c_pw;
  assign w_cnt_inc = r_cnt + c_one;
  assign w_sym_end = (r_state != S_IDLE) && (w_cnt_inc == w_len);

  // A new bit is requested at the close of the preamble and of every non-final bit.
  assign w_fetch = w_sym_end &&
                   (((r_state == S_RTCAL) && !r_pre) ||
                    (r_state == S_TRCAL) ||
                    ((r_state == S_BITS) && !r_last_bit));

  assign in_rdy   = w_fetch && !rst;
  assign tx_env   = r_env;
  assign busy     = r_busy;
  assign done     = r_done;
  assign underrun = r_underrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pre      <= 1'b0;
      r_bit      <= 1'b0;
      r_last_bit <= 1'b0;
      r_env      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (start) begin
          r_state <= S_DELIM;
          r_pre   <= use_preamble;
          r_busy  <= 1'b1;
          r_env   <= 1'b0;
        end else begin
          r_env <= 1'b1;
        end
      end else if (!w_sym_end) begin
        // tx_env is registered, so it is computed for the count being entered.
        r_cnt <= w_cnt_inc;
        r_env <= (r_state != S_DELIM) && (w_cnt_inc < w_high);
      end else begin
        r_cnt <= '0;
        r_env <= 1'b1;
        if (w_fetch) begin
          if (in_vld) begin
            r_state    <= S_BITS;
            r_bit      <= in_dat;
            r_last_bit <= in_last;
          end else begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_underrun <= 1'b1;
          end
        end else begin
          case (r_state)
            S_DELIM: r_state <= S_DATA0;
            S_DATA0: r_state <= S_RTCAL;
            S_RTCAL: r_state <= S_TRCAL;
            default: begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pie_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pie_frame_tx
// Purpose  : Scoreboard bench for pie_frame_tx against a per-cycle envelope model.
// Revision : 1.0
// ============================================================================
module tb_pie_frame_tx;

  localparam int TARI_CYC  = 8;
  localparam int DATA1_CYC = 14;
  localparam int PW_CYC    = 4;
  localparam int DELIM_CYC = 10;
  localparam int TRCAL_CYC = 40;
  localparam int CNT_WIDTH = 16;

  logic clk = 1'b0;
  logic rst, start, use_preamble, in_dat, in_last, in_vld;
  logic in_rdy, tx_env, busy, done, underrun;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct packed { int cyc; logic env; logic rdy; } samp_t;
  typedef struct packed { int cyc; logic und; } ev_t;
  samp_t env_q[$];
  ev_t   ev_q[$];

  logic drv_bits[8];
  int   drv_n   = 0;
  int   drv_ok  = 0;
  int   drv_idx = 0;
  int   hs_cnt  = 0;

  pie_frame_tx #(
    .TARI_CYC (TARI_CYC),
    .DATA1_CYC(DATA1_CYC),
    .PW_CYC   (PW_CYC),
    .DELIM_CYC(DELIM_CYC),
    .TRCAL_CYC(TRCAL_CYC),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .use_preamble(use_preamble),
    .in_dat      (in_dat),
    .in_last     (in_last),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .tx_env      (tx_env),
    .busy        (busy),
    .done        (done),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: symbol of length L = (L-PW) cycles high then PW low.
  task automatic push_sym(inout int c, input int len, input bit rdy_end);
    for (int k = 0; k < len; k++) begin
      samp_t t;
      t.cyc = c;
      t.env = (k < len - PW_CYC);
      t.rdy = rdy_end && (k == len - 1);
      env_q.push_back(t);
      c++;
    end
  endtask

  task automatic plan(input int s, input bit pre, input int nbits, input int n_ok,
                      input bit [7:0] pat, output int e);
    int c;
    ev_t ev;
    c = s + 1;
    for (int k = 0; k < DELIM_CYC; k++) begin
      samp_t t;
      t.cyc = c; t.env = 1'b0; t.rdy = 1'b0;
      env_q.push_back(t);
      c++;
    end
    push_sym(c, TARI_CYC, 1'b0);
    push_sym(c, TARI_CYC + DATA1_CYC, !pre);
    if (pre) push_sym(c, TRCAL_CYC, 1'b1);
    for (int i = 0; i < nbits; i++) begin
      if (i >= n_ok) begin
        ev.cyc = c; ev.und = 1'b1;
        ev_q.push_back(ev);
        e = c;
        return;
      end
      push_sym(c, pat[i] ? DATA1_CYC : TARI_CYC, i < nbits - 1);
    end
    ev.cyc = c; ev.und = 1'b0;
    ev_q.push_back(ev);
    e = c;
  endtask

  // Bit source: presents bit drv_idx, withholds valid once drv_ok bits are used.
  initial begin
    bit hs;
    in_vld = 1'b0; in_dat = 1'b0; in_last = 1'b0;
    forever begin
      @(negedge clk);
      hs = in_vld && in_rdy;
      @(posedge clk); #1;
      if (hs) begin
        drv_idx++;
        hs_cnt++;
      end
      in_vld  = (drv_idx < drv_ok) && (drv_idx < drv_n);
      in_dat  = (drv_idx < 8) ? drv_bits[drv_idx] : 1'b0;
      in_last = (drv_idx == drv_n - 1);
    end
  end

  // Monitor: every cycle either a planned frame sample or the idle/CW state.
  always @(negedge clk) begin
    logic e_env, e_busy, e_rdy, e_done, e_und;
    if (mon_en) begin
      e_env = 1'b1; e_busy = 1'b0; e_rdy = 1'b0; e_done = 1'b0; e_und = 1'b0;
      while (env_q.size() > 0 && env_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL stale_sample cyc=%0d actual=unconsumed expected=consumed_at_%0d", cyc, env_q[0].cyc);
        void'(env_q.pop_front());
      end
      if (env_q.size() > 0 && env_q[0].cyc == cyc) begin
        e_env  = env_q[0].env;
        e_rdy  = env_q[0].rdy;
        e_busy = 1'b1;
        void'(env_q.pop_front());
      end
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        e_done = !ev_q[0].und;
        e_und  = ev_q[0].und;
        void'(ev_q.pop_front());
      end
      chk("tx_env", tx_env, e_env);
      chk("busy", busy, e_busy);
      chk("in_rdy", in_rdy, e_rdy);
      chk("done", done, e_done);
      chk("underrun", underrun, e_und);
    end
  end

  task automatic run_frame(input bit pre, input int nbits, input int n_ok, input bit [7:0] pat,
                           input bit mid_start, input bit chain, input int rst_off);
    int s, e;
    for (int i = 0; i < 8; i++) drv_bits[i] = pat[i];
    drv_n = nbits; drv_ok = n_ok; drv_idx = 0; hs_cnt = 0;
    start = 1'b1; use_preamble = pre;
    s = cyc;
    plan(s, pre, nbits, n_ok, pat, e);
    @(posedge clk); #1;
    start = 1'b0; use_preamble = 1'($urandom);
    if (mid_start) begin
      while (cyc < s + 1 + DELIM_CYC + TARI_CYC + 5) begin @(posedge clk); #1; end
      start = 1'b1; use_preamble = !pre;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (rst_off > 0) begin
      while (cyc < s + rst_off) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      env_q.delete();
      ev_q.delete();
      return;
    end
    while (cyc < e) begin @(posedge clk); #1; end
    chk_int("handshakes", hs_cnt, (n_ok < nbits) ? n_ok : nbits);
    if (!chain) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; use_preamble = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; mon_en = 1'b1;
    repeat (20) begin @(posedge clk); #1; end

    run_frame(1'b1, 2, 2, 8'b0000_0001, 1'b0, 1'b0, 0);
    repeat (3) begin @(posedge clk); #1; end
    run_frame(1'b0, 1, 1, 8'b0000_0000, 1'b0, 1'b0, 0);
    repeat (2) begin @(posedge clk); #1; end
    run_frame(1'b1, 2, 0, 8'b0000_0011, 1'b0, 1'b0, 0);
    repeat (2) begin @(posedge clk); #1; end
    run_frame(1'b0, 3, 3, 8'b0000_0101, 1'b1, 1'b1, 0);
    run_frame(1'b1, 2, 2, 8'b0000_0010, 1'b0, 1'b0, 0);
    repeat (2) begin @(posedge clk); #1; end
    run_frame(1'b1, 2, 2, 8'b0000_0010, 1'b0, 1'b0, 78);
    repeat (4) begin @(posedge clk); #1; end
    run_frame(1'b1, 2, 2, 8'b0000_0001, 1'b0, 1'b0, 0);

    for (int f = 0; f < 10; f++) begin
      int nb, ok;
      bit [7:0] p;
      bit pre;
      nb  = $urandom_range(1, 5);
      p   = 8'($urandom);
      pre = 1'($urandom);
      ok  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : nb;
      run_frame(pre, nb, ok, p, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 0);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    repeat (5) begin @(posedge clk); #1; end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
